mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I core. It replaces single-cycle control with an FSM that steps the shared ALU, register file and unified memory port through FETCH/DECODE/EXEC/MEM/WB.
- Handles variable-latency memory via a req/ready handshake with a timeout watchdog.
- Sits between the instruction register and datapath muxes; the existing combinational ALU decoder consumes ALUOp.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles waiting on mem_ready before bus_err; 0 disables the watchdog.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]
- zero  in  1  ALU zero flag (branch compare result)
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  write strobe, qualified by mem_req
- i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load IR from memory data
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch/jump target
- reg_write  out  1  register file write enable
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC+4 (link)
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  00 rs2, 01 const 4, 10 imm
- alu_op  out  3  000 ADD, 001 SUB, 010 R-funct, 011 I-funct
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal  out  1  sticky, set on an unsupported opcode
- bus_err  out  1  sticky, set on memory timeout

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset: state = FETCH, opcode_q = 0, timeout cnt = 0, illegal = 0, bus_err = 0. All strobes read 0 during reset cycles.
- Output style: outputs are combinational from state, opcode_q and handshake inputs (Moore plus ready qualification). No output depends on opcode outside DECODE/EXEC/MEM/WB.
- FETCH:
  - Drive mem_req=1, i_or_d=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch opcode_q <= opcode.
  - Compute the branch target speculatively: alu_src_a=0, alu_src_b=10, alu_op=ADD.
  - Go to EXEC if opcode is 0110011, 0010011, 0000011, 0100011, 1100011 or 1101111.
  - Otherwise set illegal=1, pulse instr_done, and return to FETCH.
- EXEC, by class:
  - R: alu_src_a=1, alu_src_b=00, alu_op=010, then go to WB.
  - I-ALU: alu_src_b=10, alu_op=011, then go to WB.
  - LOAD/STORE: address = rs1+imm (alu_op=ADD), then go to MEM.
  - BRANCH: alu_op=001, pc_src=1, pc_write=zero & (funct3==000), instr_done=1, then go to FETCH. Only BEQ/BNE are decoded; BNE uses !zero.
  - JAL: pc_write=1, pc_src=1, reg_write=1, mem_to_reg=10, instr_done=1, then go to FETCH.
- MEM:
  - Drive mem_req=1, i_or_d=1, mem_we = (STORE).
  - On mem_ready: STORE pulses instr_done and goes to FETCH; LOAD goes to WB.
- WB:
  - reg_write=1, mem_to_reg = 01 for LOAD, else 00.
  - Pulse instr_done and go to FETCH.
- Latencies with mem_ready tied high: R/I = 4 cycles, LOAD = 5, STORE = 4, BRANCH/JAL = 3.
- Watchdog:
  - cnt increments each cycle mem_req=1 && !mem_ready, and clears on mem_ready or on a state change.
  - When cnt == TIMEOUT_CYCLES: set bus_err, drop mem_req, return to FETCH with no ir_write/reg_write/pc_write. The PC does not advance, so the access is retried.
- Simultaneous events: mem_ready in the same cycle that cnt reaches TIMEOUT_CYCLES counts as success; bus_err is not set.
- Sticky flags: illegal and bus_err clear only on rst.
- Reset mid-operation: an active mem_req drops in the cycle rst is sampled high. No write strobe (mem_we, reg_write, pc_write) may assert during a reset cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB);
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL);
  - alu_op, alu_src_b and mem_to_reg encodings.
- One natural sub-module, mem_watchdog: counter, clear, and timeout compare.

Test Plan:
- ADD (opcode 0110011, mem_ready=1) after reset → states F,D,E,W. reg_write=1 only in cycle 4 with alu_op=010. instr_done pulses in cycle 4.
- LOAD with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles, mem_we=0. WB has mem_to_reg=01. Total 8 cycles.
- BEQ with zero=1, then zero=0 → pc_write=1/pc_src=1 in EXEC for the first; pc_write=0 for the second. Both take 3 cycles.
- Opcode 1111111 → illegal=1 after DECODE, no reg_write, back to FETCH, flag stays set across the next instruction.
- FETCH with mem_ready=0 for 300 cycles, TIMEOUT_CYCLES=255 → bus_err asserts at wait cycle 255, mem_req drops, no ir_write. A retry then succeeds.
- rst asserted during MEM of a STORE → next cycle state=FETCH, mem_req=0, mem_we never high while rst=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer:
// FSM states, supported opcodes and the datapath mux/ALU select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_RFN = 3'b010;
  localparam logic [2:0] ALU_IFN = 3'b011;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MDR  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles a memory access stays unanswered and flags a timeout
// when the count reaches TIMEOUT_CYCLES (0 disables the watchdog).
module mem_watchdog
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic ready_i,
  input  logic restart_i,
  output logic timeout_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A ready on the limit cycle wins, so the compare is qualified by !ready_i.
  assign timeout_o = busy_i && !ready_i && (TIMEOUT_CYCLES != 0)
                     && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!busy_i || ready_i || restart_i || timeout_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: steps the shared ALU, register file and
// unified memory port through FETCH/DECODE/EXEC/MEM/WB with a req/ready bus.
module mc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err
);

  state_e     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       mem_busy, timeout;

  assign mem_busy = (state_q == FETCH) || (state_q == MEM);

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .busy_i   (mem_busy),
    .ready_i  (mem_ready),
    .restart_i(state_d != state_q),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = WB_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    // Reset cycles keep every strobe low; the registers are cleared in always_ff.
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          mem_req = !timeout;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = SRCB_FOUR;
            state_d   = DECODE;
          end else if (timeout) begin
            bus_err_d = 1'b1;
          end
        end
        DECODE: begin
          opcode_d  = opcode;
          alu_src_b = SRCB_IMM;
          if (op_legal(opcode)) begin
            state_d = EXEC;
          end else begin
            illegal_d  = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
        EXEC: begin
          state_d = FETCH;
          case (opcode_q)
            OP_R: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_RFN;
              state_d   = WB;
            end
            OP_I: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALU_IFN;
              state_d   = WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
              state_d   = MEM;
            end
            OP_BRANCH: begin
              alu_src_a  = 1'b1;
              alu_op     = ALU_SUB;
              pc_src     = 1'b1;
              pc_write   = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
              instr_done = 1'b1;
            end
            OP_JAL: begin
              pc_write   = 1'b1;
              pc_src     = 1'b1;
              reg_write  = 1'b1;
              mem_to_reg = WB_LINK;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req = !timeout;
          i_or_d  = 1'b1;
          mem_we  = (opcode_q == OP_STORE) && !timeout;
          if (mem_ready) begin
            if (opcode_q == OP_STORE) begin
              instr_done = 1'b1;
              state_d    = FETCH;
            end else begin
              state_d = WB;
            end
          end else if (timeout) begin
            bus_err_d = 1'b1;
            state_d   = FETCH;
          end
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode_q == OP_LOAD) ? WB_MDR : WB_ALU;
          alu_op     = (opcode_q == OP_R) ? ALU_RFN :
                       (opcode_q == OP_I) ? ALU_IFN : ALU_ADD;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule
